mem_port_arbiter: RTL and testbench

- Shares one unified, variable-latency memory port between the pipeline's instruction-fetch requester (IF) and data-memory requester (MEM stage: loads and stores).
- Serialises accesses and returns read data to each requester.
- Generates per-requester stall signals that the pipeline ORs into its existing stall and enable logic.
- Data has priority over fetch, because the MEM-stage instruction is older. A starvation limit bounds how long fetch can be starved.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/starve_counter.sv | 37 +++
 rtl/mem_port_arbiter.sv | 171 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// +--------------------------------------------------------------------+
// | mem_arb_pkg : shared state and requester encodings for the arbiter |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

endpackage

`default_nettype wire

// File: rtl/starve_counter.sv
// +--------------------------------------------------------------------+
// | starve_counter : saturating count of data grants won over fetch    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] count;

  assign at_limit = (count == LIMIT_C);

  // Clear dominates: a grant can never both bump and clear the streak.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !at_limit) begin
      count <= count + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// +--------------------------------------------------------------------+
// | mem_port_arbiter : shares one memory port between fetch and data   |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ready,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_ready,
  output logic [DW-1:0] dm_rdata,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  arb_state_t    state;
  arb_state_t    state_nx;
  logic          mem_req_nx;
  logic          mem_we_nx;
  logic [AW-1:0] mem_addr_nx;
  logic [DW-1:0] mem_wdata_nx;
  logic [DW-1:0] if_rdata_nx;
  logic [DW-1:0] dm_rdata_nx;
  logic          if_ready_nx;
  logic          dm_ready_nx;

  logic          grant_valid;
  logic          grant_id;
  logic          at_limit;
  logic          streak_inc;
  logic          streak_clr;

  // Data is older in the pipeline, so it wins unless fetch has been starved long enough.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = REQ_I;
    if (state == IDLE) begin
      if (dm_req && (!if_req || !at_limit)) begin
        grant_valid = 1'b1;
        grant_id    = REQ_D;
      end else if (if_req) begin
        grant_valid = 1'b1;
        grant_id    = REQ_I;
      end
    end
  end

  assign streak_inc = grant_valid && (grant_id == REQ_D) && if_req;
  assign streak_clr = grant_valid && ((grant_id == REQ_I) || !if_req);

  starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_counter (
    .clk      (clk),
    .reset    (reset),
    .inc      (streak_inc),
    .clr      (streak_clr),
    .at_limit (at_limit)
  );

  always_comb begin
    state_nx     = state;
    mem_req_nx   = mem_req;
    mem_we_nx    = mem_we;
    mem_addr_nx  = mem_addr;
    mem_wdata_nx = mem_wdata;
    if_rdata_nx  = if_rdata;
    dm_rdata_nx  = dm_rdata;
    if_ready_nx  = 1'b0;
    dm_ready_nx  = 1'b0;

    case (state)
      IDLE: begin
        if (grant_valid) begin
          mem_req_nx = 1'b1;
          if (grant_id == REQ_D) begin
            mem_addr_nx  = dm_addr;
            mem_we_nx    = dm_we;
            mem_wdata_nx = dm_wdata;
            state_nx     = BUSY_D;
          end else begin
            mem_addr_nx = if_addr;
            mem_we_nx   = 1'b0;
            state_nx    = BUSY_I;
          end
        end
      end

      BUSY_I: begin
        if (mem_ack) begin
          mem_req_nx  = 1'b0;
          mem_we_nx   = 1'b0;
          if_rdata_nx = mem_rdata;
          if_ready_nx = 1'b1;
          state_nx    = RESP;
        end
      end

      BUSY_D: begin
        if (mem_ack) begin
          mem_req_nx  = 1'b0;
          mem_we_nx   = 1'b0;
          // Stores keep the last load result visible to the pipeline.
          if (!mem_we) begin
            dm_rdata_nx = mem_rdata;
          end
          dm_ready_nx = 1'b1;
          state_nx    = RESP;
        end
      end

      RESP: begin
        state_nx = IDLE;
      end

      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
    end else begin
      state     <= state_nx;
      mem_req   <= mem_req_nx;
      mem_we    <= mem_we_nx;
      mem_addr  <= mem_addr_nx;
      mem_wdata <= mem_wdata_nx;
      if_rdata  <= if_rdata_nx;
      dm_rdata  <= dm_rdata_nx;
      if_ready  <= if_ready_nx;
      dm_ready  <= dm_ready_nx;
    end
  end

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = dm_req & ~dm_ready;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// +--------------------------------------------------------------------+
// | tb_mem_port_arbiter : scoreboard bench with a behavioural memory    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ready;
  logic [DW-1:0] if_rdata;
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_ready;
  logic [DW-1:0] dm_rdata;
  logic          stall_if;
  logic          stall_mem;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;

  mem_port_arbiter #(
    .AW (AW), .DW (DW), .STARVE_LIMIT (LIM)
  ) dut (
    .clk (clk), .reset (reset),
    .if_req (if_req), .if_addr (if_addr), .if_ready (if_ready), .if_rdata (if_rdata),
    .dm_req (dm_req), .dm_we (dm_we), .dm_addr (dm_addr), .dm_wdata (dm_wdata),
    .dm_ready (dm_ready), .dm_rdata (dm_rdata),
    .stall_if (stall_if), .stall_mem (stall_mem),
    .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
    .mem_ack (mem_ack), .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Expected contents (updated when a store is issued) and the device contents (updated on ack).
  logic [31:0] exp_mem [logic [31:0]];
  logic [31:0] mem_dev [logic [31:0]];
  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];
  logic        grant_log[$];
  logic [31:0] dm_last = 32'h0;

  bit resp_en = 1'b0;
  int lat_min = 0;
  int lat_max = 3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (exp_mem.exists(a)) return exp_mem[a];
    return rom(a);
  endfunction

  function automatic logic [31:0] dev_read(input logic [31:0] a);
    if (mem_dev.exists(a)) return mem_dev[a];
    return rom(a);
  endfunction

  // Memory device: acknowledges each request after a random number of wait cycles.
  initial begin
    bit in_txn;
    int lat_cnt;
    in_txn    = 1'b0;
    lat_cnt   = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!reset || mem_ack) begin
        mem_ack = 1'b0;
        in_txn  = 1'b0;
      end else if (mem_req && resp_en) begin
        if (!in_txn) begin
          in_txn  = 1'b1;
          lat_cnt = $urandom_range(lat_max, lat_min);
        end
        if (lat_cnt == 0) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            mem_dev[mem_addr] = mem_wdata;
            mem_rdata = $urandom;
          end else begin
            mem_rdata = dev_read(mem_addr);
          end
        end else begin
          lat_cnt--;
        end
      end
    end
  end

  // Monitor / scoreboard: grant order from the priority rule, ready timing, data and stalls.
  logic        prev_mem_req = 1'b0, ack_prev = 1'b0, owner_d = 1'b0;
  int          streak = 0;
  logic        p_if_req = 1'b0, p_dm_req = 1'b0, p_dm_we = 1'b0;
  logic [31:0] p_if_addr = '0, p_dm_addr = '0, p_dm_wdata = '0;
  logic [31:0] g_addr = '0, g_wdata = '0;
  logic        g_we = 1'b0;

  always @(negedge clk) begin
    logic win_d;
    if (!reset) begin
      prev_mem_req = 1'b0;
      ack_prev     = 1'b0;
      streak       = 0;
    end else begin
      chk("if_ready_timing", {31'd0, if_ready}, {31'd0, ack_prev && !owner_d});
      chk("dm_ready_timing", {31'd0, dm_ready}, {31'd0, ack_prev && owner_d});
      if (if_ready) begin
        if (if_q.size() == 0) chk("if_ready_unexpected", 32'd1, 32'd0);
        else chk("if_rdata", if_rdata, if_q.pop_front());
      end
      if (dm_ready) begin
        if (dm_q.size() == 0) chk("dm_ready_unexpected", 32'd1, 32'd0);
        else chk("dm_rdata", dm_rdata, dm_q.pop_front());
      end
      chk("stall_if", {31'd0, stall_if}, {31'd0, if_req && !if_ready});
      chk("stall_mem", {31'd0, stall_mem}, {31'd0, dm_req && !dm_ready});

      if (mem_req && !prev_mem_req) begin
        if (!p_if_req && !p_dm_req) chk("grant_without_request", 32'd1, 32'd0);
        win_d   = p_dm_req && (!p_if_req || streak < LIM);
        owner_d = win_d;
        if (win_d) streak = p_if_req ? ((streak < LIM) ? streak + 1 : LIM) : 0;
        else streak = 0;
        grant_log.push_back(win_d);
        g_addr  = win_d ? p_dm_addr : p_if_addr;
        g_we    = win_d ? p_dm_we : 1'b0;
        g_wdata = p_dm_wdata;
        chk("grant_addr", mem_addr, g_addr);
        chk("grant_we", {31'd0, mem_we}, {31'd0, g_we});
        if (g_we) chk("grant_wdata", mem_wdata, g_wdata);
      end else if (mem_req) begin
        chk("hold_addr", mem_addr, g_addr);
        chk("hold_we", {31'd0, mem_we}, {31'd0, g_we});
        if (g_we) chk("hold_wdata", mem_wdata, g_wdata);
      end else begin
        chk("idle_we_low", {31'd0, mem_we}, 32'd0);
      end
      ack_prev     = mem_ack && mem_req;
      prev_mem_req = mem_req;
    end
    p_if_req   = if_req;
    p_if_addr  = if_addr;
    p_dm_req   = dm_req;
    p_dm_addr  = dm_addr;
    p_dm_we    = dm_we;
    p_dm_wdata = dm_wdata;
  end

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic if_access(input logic [31:0] a);
    int n;
    if_q.push_back(model_read(a));
    if_addr = a;
    if_req  = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!if_ready && n < 300);
    chk("if_ready_seen", {31'd0, if_ready}, 32'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic dm_access(input logic we, input logic [31:0] a, input logic [31:0] wd);
    int n;
    if (we) begin
      exp_mem[a] = wd;
      dm_q.push_back(dm_last);
    end else begin
      dm_last = model_read(a);
      dm_q.push_back(dm_last);
    end
    dm_we    = we;
    dm_addr  = a;
    dm_wdata = wd;
    dm_req   = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!dm_ready && n < 300);
    chk("dm_ready_seen", {31'd0, dm_ready}, 32'd1);
    @(posedge clk); #1;
    dm_req = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int n;
    int d_before_i;
    reset    = 1'b0;
    if_req   = 1'b1;
    if_addr  = 32'h0000_0100;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = '0;
    dm_wdata = '0;

    // Reset held with a fetch pending: everything quiet.
    repeat (3) @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
    chk("rst_dm_ready", {31'd0, dm_ready}, 32'd0);
    chk("rst_if_rdata", if_rdata, 32'd0);
    chk("rst_dm_rdata", dm_rdata, 32'd0);
    chk("rst_stall_if", {31'd0, stall_if}, 32'd1);
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_mem_req", {31'd0, mem_req}, 32'd1);
    chk("post_rst_mem_addr", mem_addr, 32'h0000_0100);
    resp_en = 1'b1;
    if_access(32'h0000_0100);

    // Lone fetch with a fixed two-cycle memory latency.
    lat_min = 2; lat_max = 2;
    exp_mem[32'h40] = 32'h2008000A;
    mem_dev[32'h40] = 32'h2008000A;
    idle_cycles(2);
    if_access(32'h0000_0040);
    chk("lone_if_rdata", if_rdata, 32'h2008000A);
    @(negedge clk);
    chk("lone_stall_if_after", {31'd0, stall_if}, 32'd0);

    // Simultaneous requests: data first, then fetch.
    lat_min = 0; lat_max = 2;
    idle_cycles(1);
    grant_log.delete();
    fork
      if_access(32'h0000_0200);
      dm_access(1'b0, 32'h0000_0080, 32'h0);
    join
    chk("simul_grants", grant_log.size(), 32'd2);
    if (grant_log.size() == 2) begin
      chk("simul_first_d", {31'd0, grant_log[0]}, 32'd1);
      chk("simul_second_i", {31'd0, grant_log[1]}, 32'd0);
    end

    // Store keeps the previous load data on dm_rdata.
    idle_cycles(1);
    dm_access(1'b1, 32'h0000_0054, 32'hDEADBEEF);
    chk("store_dm_rdata_kept", dm_rdata, dm_last);
    dm_access(1'b0, 32'h0000_0054, 32'h0);

    // An ack with no transaction in flight must not produce a ready.
    idle_cycles(1);
    @(posedge clk); #2;
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    repeat (3) @(negedge clk);
    chk("stray_ack_dm_rdata", dm_rdata, dm_last);

    // Starvation: fetch held while data re-requests back to back.
    idle_cycles(1);
    dm_access(1'b0, 32'h1000_0000, 32'h0);
    grant_log.delete();
    fork
      if_access(32'h0000_0300);
      begin
        for (int i = 0; i < LIM + 2; i++)
          dm_access(i[0], 32'h1000_0000 + 32'(4 * i), $urandom);
      end
    join
    d_before_i = 0;
    while (d_before_i < grant_log.size() && grant_log[d_before_i]) d_before_i++;
    chk("starve_d_before_i", d_before_i, LIM);
    chk("starve_total_grants", grant_log.size(), LIM + 3);

    // Randomised concurrent traffic.
    lat_min = 0; lat_max = 3;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          idle_cycles($urandom_range(3, 0));
          if_access({22'd0, 8'($urandom_range(255, 0)), 2'b00});
        end
      end
      begin
        for (int j = 0; j < 40; j++) begin
          idle_cycles($urandom_range(2, 0));
          dm_access(1'($urandom_range(1, 0)), 32'h1000_0000 + 32'(4 * $urandom_range(7, 0)), $urandom);
        end
      end
    join

    // Reset in the middle of a data access.
    resp_en = 1'b0;
    idle_cycles(1);
    dm_we = 1'b0; dm_addr = 32'h1000_0004; dm_req = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 20);
    chk("midrst_busy", {31'd0, mem_req}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("midrst_mem_req_drop", {31'd0, mem_req}, 32'd0);
    chk("midrst_dm_rdata", dm_rdata, 32'd0);
    dm_req  = 1'b0;
    dm_last = 32'h0;
    @(negedge clk);
    #2 reset = 1'b1;
    resp_en = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_idle", {31'd0, mem_req}, 32'd0);

    chk("if_q_drained", if_q.size(), 32'd0);
    chk("dm_q_drained", dm_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
